// File: rtl/cpu_isa_pkg.sv
// Shared ISA definitions: instruction formats, key opcodes, field positions
// and a helper that slices a MIPS-style 32-bit word into its decoded fields.
package cpu_isa_pkg;

   typedef enum logic [1:0] {
      FMT_R = 2'd0,
      FMT_I = 2'd1,
      FMT_J = 2'd2
   } fmt_t;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_JAL   = 6'h03;

   // Least-significant bit of each field in the 32-bit encoding
   localparam int OPCODE_LSB = 26;
   localparam int RS_LSB     = 21;
   localparam int RT_LSB     = 16;
   localparam int RD_LSB     = 11;
   localparam int SHAMT_LSB  = 6;
   localparam int FUNCT_LSB  = 0;
   localparam int JADDR_LSB  = 0;

   typedef struct packed {
      logic [5:0]  opcode;
      logic [4:0]  rs;
      logic [4:0]  rt;
      logic [4:0]  rd;
      logic [4:0]  shamt;
      logic [5:0]  funct;
      logic [25:0] jaddr;
      fmt_t        fmt;
   } fields_t;

   // Pure slicing plus format classification; no state involved
   function automatic fields_t decode_word(input logic [31:0] word);
      fields_t f;
      f.opcode = word[OPCODE_LSB +: 6];
      f.rs     = word[RS_LSB +: 5];
      f.rt     = word[RT_LSB +: 5];
      f.rd     = word[RD_LSB +: 5];
      f.shamt  = word[SHAMT_LSB +: 5];
      f.funct  = word[FUNCT_LSB +: 6];
      f.jaddr  = word[JADDR_LSB +: 26];
      if (f.opcode == OP_RTYPE)
         f.fmt = FMT_R;
      else if (f.opcode == OP_J || f.opcode == OP_JAL)
         f.fmt = FMT_J;
      else
         f.fmt = FMT_I;
      return f;
   endfunction

endpackage

// File: rtl/sync_fifo.sv
// Generic single-clock FIFO with synchronous flush. The head word is visible
// combinationally on dout so a consumer can capture it on the popping edge.
module sync_fifo #(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 4,
   localparam int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              push,
   input  logic              pop,
   input  logic              flush,
   input  logic [DATA_W-1:0] din,
   output logic [DATA_W-1:0] dout,
   output logic              full,
   output logic              empty,
   output logic [CNT_W-1:0]  count
);

   localparam int PTR_W = $clog2(DEPTH);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   logic              do_push;
   logic              do_pop;

   // Flush wins over both sides; a full FIFO refuses pushes even when popping
   assign do_push = push && !full && !flush;
   assign do_pop  = pop && !empty && !flush;

   assign full  = (count == CNT_W'(DEPTH));
   assign empty = (count == '0);
   assign dout  = mem[rd_ptr];

   // Storage write at the tail; contents need no reset since count gates use
   always_ff @(posedge clk) begin
      if (do_push)
         mem[wr_ptr] <= din;
   end

   // Pointers wrap naturally because DEPTH is a power of two
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push)
            wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)
            rd_ptr <= rd_ptr + 1'b1;
      end
   end

   // Occupancy: simultaneous push and pop leaves it unchanged
   always_ff @(posedge clk) begin
      if (rst || flush)
         count <= '0;
      else if (do_push && !do_pop)
         count <= count + CNT_W'(1);
      else if (do_pop && !do_push)
         count <= count - CNT_W'(1);
   end

endmodule

// File: rtl/instr_queue_decoder.sv
// Instruction buffer in front of a registered decoder: fetched words queue in
// a FIFO and each ir_write loads the head word's fields into output registers.
module instr_queue_decoder
   import cpu_isa_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 4,
   parameter int IMM_W  = 16,
   localparam int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_instr,
   input  logic              ir_write,
   input  logic              flush,
   output logic              out_valid,
   output logic [5:0]        opcode,
   output logic [4:0]        rs,
   output logic [4:0]        rt,
   output logic [4:0]        rd,
   output logic [4:0]        shamt,
   output logic [5:0]        funct,
   output logic [IMM_W-1:0]  imm,
   output logic [DATA_W-1:0] imm_sext,
   output logic [25:0]       jaddr,
   output logic [1:0]        fmt,
   output logic [CNT_W-1:0]  count
);

   logic [DATA_W-1:0] head_word;
   logic              full;
   logic              empty;
   fields_t           head_fields;
   fields_t           ir_fields;
   logic [IMM_W-1:0]  head_imm;

   sync_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (in_valid),
      .pop   (ir_write),
      .flush (flush),
      .din   (in_instr),
      .dout  (head_word),
      .full  (full),
      .empty (empty),
      .count (count)
   );

   assign in_ready    = !full;
   assign head_fields = decode_word(head_word[31:0]);
   assign head_imm    = head_word[IMM_W-1:0];

   // Instruction register: loads only on a successful pop, otherwise holds
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid <= 1'b0;
         ir_fields <= '0;
         imm       <= '0;
         imm_sext  <= '0;
      end else if (flush) begin
         out_valid <= 1'b0;
      end else if (ir_write) begin
         if (!empty) begin
            out_valid <= 1'b1;
            ir_fields <= head_fields;
            imm       <= head_imm;
            imm_sext  <= {{(DATA_W-IMM_W){head_imm[IMM_W-1]}}, head_imm};
         end else begin
            out_valid <= 1'b0;
         end
      end
   end

   assign opcode = ir_fields.opcode;
   assign rs     = ir_fields.rs;
   assign rt     = ir_fields.rt;
   assign rd     = ir_fields.rd;
   assign shamt  = ir_fields.shamt;
   assign funct  = ir_fields.funct;
   assign jaddr  = ir_fields.jaddr;
   assign fmt    = ir_fields.fmt;

endmodule
